// File: rtl/vga1306_framebuffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga1306_pkg
// Description : Shared timing defaults, geometry helpers and pipeline types
//               for the VGA1306 framebuffer display path.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package vga1306_pkg;

  // Default 640x480@60 raster timing
  localparam int DEF_H_PIXELS = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_PULSE  = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_POL    = 0;
  localparam int DEF_V_PIXELS = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_PULSE  = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_POL    = 1;

  // Total counter length of one axis
  function automatic int frame_len(input int pixels, input int fp, input int pulse, input int bp);
    return pixels + fp + pulse + bp;
  endfunction

  // Centring offset of the scaled panel inside the active area (negative = does not fit)
  function automatic int win_origin(input int pixels, input int panel, input int scale_log2);
    return (pixels - (panel << scale_log2)) / 2;
  endfunction

  // Number of page bytes held for the panel
  function automatic int ram_depth(input int w, input int h);
    return (w * h) / 8;
  endfunction

  // Counter / address width, never below one bit
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ram_addr_w(input int w, input int h);
    return cnt_w(ram_depth(w, h));
  endfunction

  // Everything the colour stage needs, captured alongside the RAM read
  typedef struct packed {
    logic       win;
    logic       hs;
    logic       vs;
    logic       vblank;
    logic [2:0] bit_sel;
  } fetch_t;

endpackage
`default_nettype wire

// File: rtl/vga1306_framebuffer_if.sv
`default_nettype none
// ============================================================================
// Module      : vga1306_framebuffer_if
// Description : Byte-stream write port into the panel image.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
interface vga1306_framebuffer_if;
  logic       wr_en;
  logic       wr_sof;
  logic [7:0] wr_data;

  modport master (output wr_en, output wr_sof, output wr_data);
  modport slave  (input  wr_en, input  wr_sof, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/vga1306_framebuffer_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Horizontal/vertical raster counters with raw sync, active
//               and vblank flags decoded straight from the counters.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module vga_timing_gen
  import vga1306_pkg::*;
#(
  parameter int H_PIXELS = DEF_H_PIXELS,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_PULSE  = DEF_H_PULSE,
  parameter int H_BP     = DEF_H_BP,
  parameter int H_POL    = DEF_H_POL,
  parameter int V_PIXELS = DEF_V_PIXELS,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_PULSE  = DEF_V_PULSE,
  parameter int V_BP     = DEF_V_BP,
  parameter int V_POL    = DEF_V_POL,
  localparam int HW = cnt_w(frame_len(H_PIXELS, H_FP, H_PULSE, H_BP)),
  localparam int VW = cnt_w(frame_len(V_PIXELS, V_FP, V_PULSE, V_BP))
) (
  input  logic          CLK25MHz,
  input  logic          reset,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hs,
  output logic          vs,
  output logic          active,
  output logic          vblank
);

  localparam int H_FRAME = frame_len(H_PIXELS, H_FP, H_PULSE, H_BP);
  localparam int V_FRAME = frame_len(V_PIXELS, V_FP, V_PULSE, V_BP);

  localparam logic [HW-1:0] H_LAST   = HW'(H_FRAME - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_FRAME - 1);
  localparam logic [HW-1:0] HS_START = HW'(H_PIXELS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_PIXELS + H_FP + H_PULSE - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_PIXELS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_PIXELS + V_FP + V_PULSE - 1);
  localparam logic [HW-1:0] H_ACT_N  = HW'(H_PIXELS);
  localparam logic [VW-1:0] V_ACT_N  = VW'(V_PIXELS);
  localparam logic          H_ACT    = (H_POL != 0);
  localparam logic          V_ACT    = (V_POL != 0);

  // Raster position: h wraps every line, v advances on each h wrap
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  // Raw sync and region flags decoded from the current position
  always_comb begin
    hs     = ((h >= HS_START) && (h <= HS_END)) ? H_ACT : ~H_ACT;
    vs     = ((v >= VS_START) && (v <= VS_END)) ? V_ACT : ~V_ACT;
    active = (h < H_ACT_N) && (v < V_ACT_N);
    vblank = (v >= V_ACT_N);
  end

endmodule
`default_nettype wire

// File: rtl/vga1306_framebuffer.sv
`default_nettype none
// ============================================================================
// Module      : vga1306_framebuffer
// Description : SSD1306-layout page-byte image store, written through a byte
//               stream and scaled onto a centred window of a VGA raster.
//               Two-stage pipeline: RAM fetch, then colour select.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module vga1306_framebuffer
  import vga1306_pkg::*;
#(
  parameter int OLED_W     = 128,
  parameter int OLED_H     = 64,
  parameter int SCALE_LOG2 = 2,
  parameter int H_PIXELS   = DEF_H_PIXELS,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_PULSE    = DEF_H_PULSE,
  parameter int H_BP       = DEF_H_BP,
  parameter int H_POL      = DEF_H_POL,
  parameter int V_PIXELS   = DEF_V_PIXELS,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_PULSE    = DEF_V_PULSE,
  parameter int V_BP       = DEF_V_BP,
  parameter int V_POL      = DEF_V_POL
) (
  input  logic                  CLK25MHz,
  input  logic                  reset,
  vga1306_framebuffer_if.slave  wr,
  input  logic [2:0]            fg_rgb,
  input  logic [2:0]            bg_rgb,
  input  logic                  invert,
  input  logic                  display_on,
  output logic                  vga_r,
  output logic                  vga_g,
  output logic                  vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  vblank
);

  localparam int HW    = cnt_w(frame_len(H_PIXELS, H_FP, H_PULSE, H_BP));
  localparam int VW    = cnt_w(frame_len(V_PIXELS, V_FP, V_PULSE, V_BP));
  localparam int WIN_W = OLED_W << SCALE_LOG2;
  localparam int WIN_H = OLED_H << SCALE_LOG2;
  localparam int X0    = win_origin(H_PIXELS, OLED_W, SCALE_LOG2);
  localparam int Y0    = win_origin(V_PIXELS, OLED_H, SCALE_LOG2);
  localparam int DEPTH = ram_depth(OLED_W, OLED_H);
  localparam int AW    = ram_addr_w(OLED_W, OLED_H);
  localparam int CW    = cnt_w(OLED_W);
  localparam int RW    = cnt_w(OLED_H);

  localparam logic [HW-1:0] X0_C     = HW'(X0);
  localparam logic [HW-1:0] X1_C     = HW'(X0 + WIN_W - 1);
  localparam logic [VW-1:0] Y0_C     = VW'(Y0);
  localparam logic [VW-1:0] Y1_C     = VW'(Y0 + WIN_H - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = (DEPTH > 1) ? AW'(1) : '0;
  localparam logic          H_ACT    = (H_POL != 0);
  localparam logic          V_ACT    = (V_POL != 0);

  // Refuse to build a window that spills outside the active area
  generate
    if ((X0 < 0) || (Y0 < 0) || ((OLED_H % 8) != 0) || (DEPTH < 1)) begin : g_geometry_check
      $error("vga1306_framebuffer: panel geometry does not fit the active area");
    end
  endgenerate

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          raw_hs;
  logic          raw_vs;
  logic          raw_active;
  logic          raw_vblank;

  vga_timing_gen #(
    .H_PIXELS (H_PIXELS), .H_FP (H_FP), .H_PULSE (H_PULSE), .H_BP (H_BP), .H_POL (H_POL),
    .V_PIXELS (V_PIXELS), .V_FP (V_FP), .V_PULSE (V_PULSE), .V_BP (V_BP), .V_POL (V_POL)
  ) u_timing (
    .CLK25MHz (CLK25MHz),
    .reset    (reset),
    .h        (h),
    .v        (v),
    .hs       (raw_hs),
    .vs       (raw_vs),
    .active   (raw_active),
    .vblank   (raw_vblank)
  );

  // ---------------------------------------------------------------- scaler
  logic          in_window;
  logic [HW-1:0] h_off;
  logic [VW-1:0] v_off;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] rd_addr;

  // Map the raster position to a panel byte address and bit-in-page
  always_comb begin
    in_window = raw_active && (h >= X0_C) && (h <= X1_C) && (v >= Y0_C) && (v <= Y1_C);
    h_off     = h - X0_C;
    v_off     = v - Y0_C;
    col       = CW'(h_off >> SCALE_LOG2);
    row       = RW'(v_off >> SCALE_LOG2);
    rd_addr   = '0;
    if (in_window) begin
      rd_addr = AW'((int'(row) >> 3) * OLED_W + int'(col));
    end
  end

  // ------------------------------------------------------------ write port
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_addr;

  assign wr_addr = wr.wr_sof ? '0 : wr_ptr;

  // Stream pointer: sof rewinds, a byte written with sof leaves it at 1
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (wr.wr_sof) begin
      wr_ptr <= wr.wr_en ? PTR_ONE : '0;
    end else if (wr.wr_en) begin
      wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
    end
  end

  // ------------------------------------------------------------- image RAM
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_byte;

  // Read-first RAM: a same-address write is seen on the following access
  always_ff @(posedge CLK25MHz) begin
    if (wr.wr_en) begin
      mem[wr_addr] <= wr.wr_data;
    end
    rd_byte <= mem[rd_addr];
  end

  // ----------------------------------------------------------- fetch stage
  fetch_t fetch;

  // Side-band flags travel next to the RAM read so they line up with rd_byte
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      fetch <= '{win: 1'b0, hs: ~H_ACT, vs: ~V_ACT, vblank: 1'b0, bit_sel: 3'd0};
    end else begin
      fetch <= '{win: in_window, hs: raw_hs, vs: raw_vs, vblank: raw_vblank, bit_sel: row[2:0]};
    end
  end

  // ---------------------------------------------------------- colour stage
  logic [2:0] rgb;

  // Colour select with live fg/bg/invert/display_on; black outside the window
  always_ff @(posedge CLK25MHz) begin
    if (reset) begin
      rgb    <= 3'b000;
      vga_hs <= ~H_ACT;
      vga_vs <= ~V_ACT;
      vblank <= 1'b0;
    end else begin
      vga_hs <= fetch.hs;
      vga_vs <= fetch.vs;
      vblank <= fetch.vblank;
      if (fetch.win && display_on) begin
        rgb <= (rd_byte[fetch.bit_sel] ^ invert) ? fg_rgb : bg_rgb;
      end else begin
        rgb <= 3'b000;
      end
    end
  end

  assign vga_r = rgb[2];
  assign vga_g = rgb[1];
  assign vga_b = rgb[0];

endmodule
`default_nettype wire

// File: tb/tb_vga1306_framebuffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga1306_framebuffer
// Description : Self-checking bench: a reduced raster instance checked every
//               cycle against a pixel-rule model, plus a default-timing
//               instance pinned to literal sync positions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga1306_framebuffer;

  // Reduced geometry so whole frames fit in a short run
  localparam int OW = 16, OH = 16, SL = 1;
  localparam int HP = 64, HFP = 4, HPU = 8, HBP = 4, HPOL = 0;
  localparam int VP = 48, VFP = 2, VPU = 2, VBP = 3, VPOL = 1;
  localparam int HF = HP + HFP + HPU + HBP;   // 80
  localparam int VF = VP + VFP + VPU + VBP;   // 55
  localparam int X0 = (HP - (OW << SL)) / 2;  // 16
  localparam int Y0 = (VP - (OH << SL)) / 2;  // 8
  localparam int DEPTH = OW * OH / 8;         // 32

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] fg = 3'd7, bg = 3'd0;
  logic inv = 1'b0, disp = 1'b1;
  logic r, g, b, hs, vs, vb;
  logic dr, dg, db, dhs, dvs, dvb;

  always #20 clk = ~clk;

  vga1306_framebuffer_if wif();
  vga1306_framebuffer_if dif();

  vga1306_framebuffer #(
    .OLED_W (OW), .OLED_H (OH), .SCALE_LOG2 (SL),
    .H_PIXELS (HP), .H_FP (HFP), .H_PULSE (HPU), .H_BP (HBP), .H_POL (HPOL),
    .V_PIXELS (VP), .V_FP (VFP), .V_PULSE (VPU), .V_BP (VBP), .V_POL (VPOL)
  ) dut (
    .CLK25MHz (clk), .reset (rst), .wr (wif.slave),
    .fg_rgb (fg), .bg_rgb (bg), .invert (inv), .display_on (disp),
    .vga_r (r), .vga_g (g), .vga_b (b), .vga_hs (hs), .vga_vs (vs), .vblank (vb)
  );

  vga1306_framebuffer u_def (
    .CLK25MHz (clk), .reset (rst), .wr (dif.slave),
    .fg_rgb (3'd7), .bg_rgb (3'd5), .invert (1'b0), .display_on (1'b1),
    .vga_r (dr), .vga_g (dg), .vga_b (db), .vga_hs (dhs), .vga_vs (dvs), .vblank (dvb)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [7:0] mem_m [DEPTH];
  bit         known [DEPTH];
  int  ptr_m = 0, m_h = 0, m_v = 0;
  bit  started = 0;
  // pixel fetched one cycle ago
  bit  s1_win, s1_pix, s1_known, s1_ok;
  int  s1_hs, s1_vs, s1_vb, s1_h, s1_v;
  // value the outputs must hold now
  bit  e_known, e_ok;
  int  e_rgb, e_hs, e_vs, e_vb, e_h, e_v;
  logic [2:0] scr [VF][HF];
  logic vsr [VF];
  logic vbr [VF];
  int  frames = 0;
  int  rel_idx = 0;
  bit  fall_pend = 0;
  int  def_idx = 0;
  bit  def_done = 0;

  always @(negedge clk) begin
    int col, row, addr;
    // compare current outputs
    if (started) begin
      chk("hs", hs, e_hs);
      chk("vs", vs, e_vs);
      chk("vblank", vb, e_vb);
      if (e_known) chk("rgb", {r, g, b}, e_rgb);
      if (e_ok) begin
        scr[e_v][e_h] = {r, g, b};
        if (e_h == 0) begin
          vsr[e_v] = vs;
          vbr[e_v] = vb;
        end
        if (e_h == HF - 1 && e_v == VF - 1) frames++;
      end
    end
    // first hs fall after each reset release
    if (rst) begin
      rel_idx = 0;
      fall_pend = 1;
    end else begin
      if (fall_pend && hs == 1'b0) begin
        chk("hs_first_fall", rel_idx, 70);
        fall_pend = 0;
      end
      rel_idx++;
    end
    // default-timing instance over its first two lines
    if (rst) begin
      def_idx = 0;
    end else if (!def_done && started) begin
      chk("def_hs", dhs, ((def_idx >= 658 && def_idx < 754) || (def_idx >= 1458 && def_idx < 1554)) ? 0 : 1);
      chk("def_vs", dvs, 0);
      chk("def_vblank", dvb, 0);
      chk("def_rgb", {dr, dg, db}, 0);
      def_idx++;
      if (def_idx == 1600) def_done = 1;
    end
    // advance model across the coming clock edge
    if (rst) begin
      started = 1;
      e_rgb = 0; e_hs = (HPOL == 0); e_vs = (VPOL == 0); e_vb = 0; e_known = 1; e_ok = 0;
      s1_win = 0; s1_ok = 0; s1_hs = (HPOL == 0); s1_vs = (VPOL == 0); s1_vb = 0;
      m_h = 0; m_v = 0;
    end else if (started) begin
      e_ok = s1_ok; e_h = s1_h; e_v = s1_v;
      e_hs = s1_hs; e_vs = s1_vs; e_vb = s1_vb;
      if (s1_win && disp) begin
        e_known = s1_known;
        e_rgb = (s1_pix ^ inv) ? int'(fg) : int'(bg);
      end else begin
        e_known = 1;
        e_rgb = 0;
      end
      s1_ok = 1; s1_h = m_h; s1_v = m_v;
      s1_hs = (m_h >= HP + HFP && m_h < HP + HFP + HPU) ? HPOL : int'(HPOL == 0);
      s1_vs = (m_v >= VP + VFP && m_v < VP + VFP + VPU) ? VPOL : int'(VPOL == 0);
      s1_vb = (m_v >= VP);
      s1_win = (m_h >= X0 && m_h < X0 + (OW << SL) && m_v >= Y0 && m_v < Y0 + (OH << SL));
      if (s1_win) begin
        col = (m_h - X0) >> SL;
        row = (m_v - Y0) >> SL;
        addr = (row / 8) * OW + col;
        s1_pix = mem_m[addr][row % 8];
        s1_known = known[addr];
      end
      m_h++;
      if (m_h == HF) begin
        m_h = 0;
        m_v = (m_v == VF - 1) ? 0 : m_v + 1;
      end
    end
    // write port: data lands after this cycle's read
    if (wif.wr_en) begin
      addr = wif.wr_sof ? 0 : ptr_m;
      mem_m[addr] = wif.wr_data;
      known[addr] = 1;
    end
    if (rst) ptr_m = 0;
    else if (wif.wr_sof) ptr_m = wif.wr_en ? 1 : 0;
    else if (wif.wr_en) ptr_m = (ptr_m + 1) % DEPTH;
  end

  // ------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frame();
    int f0 = frames;
    int n = 0;
    while (frames == f0 && n < 2 * HF * VF) begin
      tick();
      n++;
    end
    if (frames == f0) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: got no frame end, expected one within %0d cycles", 2 * HF * VF);
    end
  endtask

  task automatic put(input logic sof, input logic en, input logic [7:0] d);
    wif.wr_sof = sof;
    wif.wr_en = en;
    wif.wr_data = d;
    tick();
    wif.wr_sof = 1'b0;
    wif.wr_en = 1'b0;
  endtask

  initial begin
    int n;
    wif.wr_en = 1'b0; wif.wr_sof = 1'b0; wif.wr_data = 8'h00;
    dif.wr_en = 1'b0; dif.wr_sof = 1'b0; dif.wr_data = 8'h00;
    repeat (4) tick();
    rst = 1'b0;

    // 1: one free-running frame, sync/vblank line positions
    wait_frame();
    chk("vs_line49", vsr[49], 0);
    chk("vs_line50", vsr[50], 1);
    chk("vs_line51", vsr[51], 1);
    chk("vs_line52", vsr[52], 0);
    chk("vblank_line47", vbr[47], 0);
    chk("vblank_line48", vbr[48], 1);
    chk("vblank_line54", vbr[54], 1);
    chk("vblank_line0", vbr[0], 0);

    // clear the image, then 2: single set pixel at panel (0,0)
    put(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < DEPTH; i++) put(1'b0, 1'b1, 8'h00);
    fg = 3'd7; bg = 3'd0; inv = 1'b0; disp = 1'b1;
    put(1'b1, 1'b0, 8'h00);
    put(1'b0, 1'b1, 8'h01);
    for (int i = 1; i < DEPTH; i++) put(1'b0, 1'b1, 8'h00);
    wait_frame();
    chk("t2_block_tl", scr[8][16], 7);
    chk("t2_block_br", scr[9][17], 7);
    chk("t2_row1", scr[10][16], 0);
    chk("t2_left_of_win", scr[8][15], 0);
    chk("t2_right_of_win", scr[8][48], 0);

    // 3: inverted with distinct colours
    inv = 1'b1; fg = 3'b100; bg = 3'b001;
    wait_frame();
    chk("t3_block", scr[8][16], 1);
    chk("t3_block_br", scr[9][17], 1);
    chk("t3_window", scr[20][30], 4);
    chk("t3_window_corner", scr[39][47], 4);
    chk("t3_outside_left", scr[8][15], 0);
    chk("t3_below_win", scr[40][16], 0);

    // 4: one byte past the end wraps back onto address 0
    inv = 1'b0; fg = 3'd7; bg = 3'd2;
    put(1'b1, 1'b0, 8'h00);
    put(1'b0, 1'b1, 8'hFF);
    for (int i = 1; i <= DEPTH; i++) put(1'b0, 1'b1, 8'h00);
    wait_frame();
    chk("t4_wrapped", scr[8][16], 2);
    chk("t4_wrapped_br", scr[9][17], 2);

    // 5: sof together with a byte, then a plain byte
    put(1'b1, 1'b1, 8'h80);
    put(1'b0, 1'b1, 8'h01);
    wait_frame();
    chk("t5_addr0_bit7", scr[22][16], 7);
    chk("t5_addr0_bit7_br", scr[23][17], 7);
    chk("t5_addr1_bit0", scr[8][18], 7);
    chk("t5_addr1_bit0_br", scr[9][19], 7);
    chk("t5_addr0_bit0", scr[8][16], 2);
    chk("t5_addr0_bit6", scr[21][16], 2);

    // 6: one-cycle reset mid-line
    n = 0;
    while (!(m_h == 30 && m_v == 20) && n < 2 * HF * VF) begin
      tick();
      n++;
    end
    chk("t6_reached_h30_v20", (m_h == 30 && m_v == 20), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_rgb", {r, g, b}, 0);
    chk("t6_rst_hs", hs, 1);
    chk("t6_rst_vs", vs, 0);
    wait_frame();
    chk("t6_mem_kept_a0", scr[22][16], 7);
    chk("t6_mem_kept_a1", scr[8][18], 7);
    chk("t6_vs_line50", vsr[50], 1);
    chk("t6_vs_line49", vsr[49], 0);

    // randomized traffic against the model
    for (int i = 0; i < 12000; i++) begin
      rst = ($urandom_range(0, 2999) == 0);
      wif.wr_en = !rst && ($urandom_range(0, 2) == 0);
      wif.wr_sof = ($urandom_range(0, 19) == 0);
      wif.wr_data = 8'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        fg = 3'($urandom);
        bg = 3'($urandom);
        inv = 1'($urandom);
        disp = ($urandom_range(0, 3) != 0);
      end
      tick();
    end
    rst = 1'b0;
    wif.wr_en = 1'b0;
    wif.wr_sof = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
